booth_pp_accumulator: RTL and testbench
=======================================

Name: booth_pp_accumulator

Overview:
- Sequential reduction stage directly downstream of the radix-4 Booth partial-product generator.
- Accepts one set of four pre-weighted, sign-extended 16-bit partial products (pp0..pp3) per transaction.
- Sums them with a single shared adder, one partial product per cycle.
- Presents the signed 16-bit product with a valid/ready handshake.

Parameters:
- WIDTH, 16, width of each partial product, accumulator and product.
- NPP, 4, number of partial products per transaction; counter width is clog2(NPP).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  partial-product set valid
- in_ready  output  1  block can accept a set
- pp0  input  WIDTH  signed partial product, weight already applied
- pp1  input  WIDTH  signed partial product, weight already applied
- pp2  input  WIDTH  signed partial product, weight already applied
- pp3  input  WIDTH  signed partial product, weight already applied
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  WIDTH  signed sum pp0+pp1+pp2+pp3, modulo 2^WIDTH
- busy  output  1  high in ACC or DONE
- ovf  output  1  signed overflow flag (present only with BOOTH_ACC_OVF_EN)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, cnt=0, product=0, out_valid=0, busy=0, ovf=0; pp holding registers cleared. in_ready=0 while rst_n=0.
- Reset mid-transaction: operation is aborted and no product is emitted.
- States are IDLE, ACC and DONE.
- in_ready=1 only in IDLE, and is a pure decode of state.
- IDLE: on in_valid&&in_ready at an edge, latch pp0..pp3 into holding regs, acc<=0, cnt<=0, go to ACC. in_valid without in_ready is ignored. Upstream holds pp inputs stable while in_valid=1 and in_ready=0.
- ACC: each cycle acc<=acc+pp_reg[cnt] and cnt<=cnt+1. All arithmetic is two's-complement, WIDTH bits, wrap on overflow.
- ACC exit: when cnt==NPP-1, the final add is written into product (and acc), out_valid<=1, go to DONE.
- Latency: out_valid rises exactly NPP edges after the accepting edge (4 for default). Throughput is one transaction per NPP+2 cycles minimum.
- DONE: product and out_valid are held stable until out_ready=1. On out_valid&&out_ready: out_valid<=0, go to IDLE. product keeps its last value after handoff.
- out_ready while in IDLE or ACC has no effect.
- New inputs cannot be accepted in DONE, including the cycle in which out_ready is asserted. in_ready rises on the edge after the handshake.
- busy = (state != IDLE).
- Counter: cnt never exceeds NPP-1 and returns to 0 on each new accept.
- Inputs are not sampled outside the accept edge; changes during ACC/DONE are ignored.

Optional Feature:
- Macro: BOOTH_ACC_OVF_EN.
- With the macro:
  - acc is extended to WIDTH+1 bits internally (sign-extended adds).
  - ovf port exists. It is set in the same edge product is written, when the WIDTH+1-bit sum's top two bits differ.
  - ovf is held with product and cleared on the next accept or on reset.
  - product is still the low WIDTH bits (wrapped).
- Without the macro: no ovf port, WIDTH-bit accumulator, identical product and timing.

Test Plan:
- Reset: assert rst_n=0 mid-ACC -> out_valid=0, product=16'h0000, in_ready=1 after rst_n deasserts; no product emitted for the aborted set.
- Basic (M=3,X=5): pp={16'h0003,16'h000C,16'h0000,16'h0000}, in_valid one cycle, out_ready=1 -> out_valid exactly 4 edges after accept, product=16'h000F, one-cycle out_valid.
- Negative (M=-7,X=3): pp={16'h0007,16'hFFE4,16'h0000,16'h0000} -> product=16'hFFEB (-21).
- Backpressure: out_ready=0 for 5 cycles after out_valid -> product/out_valid stable, in_ready=0, a new in_valid ignored; out_ready=1 -> out_valid falls next edge, in_ready=1.
- Back-to-back: second set offered continuously after first {1,2,4,8} -> accepted only on the edge after the first handoff. Products are 16'h000F, then second sum {16'hFF80,16'h0000,16'h0000,16'h0000} -> 16'hFF80.
- Overflow (BOOTH_ACC_OVF_EN): pp={16'h7FFF,16'h0001,0,0} -> product=16'h8000, ovf=1. Next set {1,1,1,1} -> ovf=0, product=16'h0004. Without the macro, same product.

Source files
------------

// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator: adds the four pre-weighted Booth partial products of
// one transaction using a single shared adder, one product per cycle, and
// returns the signed WIDTH-bit sum through a valid/ready handshake.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   partial-product set handshake (in_ready only in IDLE)
//   pp0..pp3            signed, sign-extended, pre-weighted partial products
//   out_valid/out_ready product handshake, product held until accepted
//   product             pp0+pp1+pp2+pp3 modulo 2^WIDTH
//   busy                high while accumulating or holding a result
//   ovf                 signed overflow of the full sum (BOOTH_ACC_OVF_EN only)
//
// Optional feature macro: BOOTH_ACC_OVF_EN (one guard bit on the accumulator
// plus the ovf output). Default build leaves it out.
module booth_pp_accumulator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NPP   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pp0,
  input  logic [WIDTH-1:0] pp1,
  input  logic [WIDTH-1:0] pp2,
  input  logic [WIDTH-1:0] pp3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product,
  output logic             busy
`ifdef BOOTH_ACC_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (NPP > 1) ? $clog2(NPP) : 1;
`ifdef BOOTH_ACC_OVF_EN
  localparam int unsigned AW = WIDTH + 1;
`else
  localparam int unsigned AW = WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [AW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pp_reg [NPP];
  logic [WIDTH-1:0] pp_in  [NPP];
  logic [AW-1:0]    pp_ext;
  logic [AW-1:0]    sum;

  assign pp_in[0] = pp0;
  assign pp_in[1] = pp1;
  assign pp_in[2] = pp2;
  assign pp_in[3] = pp3;

  // Shared adder: sign-extend the selected product to the accumulator width.
  assign pp_ext = AW'($signed(pp_reg[cnt]));
  assign sum    = acc + pp_ext;

  // Status decodes; in_ready is forced low while reset is asserted.
  assign in_ready = rst_n && (state == IDLE);
  assign busy     = (state != IDLE);

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      product   <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NPP; i++) pp_reg[i] <= '0;
`ifdef BOOTH_ACC_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NPP; i++) pp_reg[i] <= pp_in[i];
            acc   <= '0;
            cnt   <= '0;
            state <= ACC;
`ifdef BOOTH_ACC_OVF_EN
            ovf   <= 1'b0;
`endif
          end
        end
        ACC: begin
          acc <= sum;
          if (cnt == CW'(NPP - 1)) begin
            // Final add goes straight to the product register.
            product   <= sum[WIDTH-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef BOOTH_ACC_OVF_EN
            ovf       <= sum[AW-1] ^ sum[AW-2];
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Scoreboard bench for booth_pp_accumulator: the driver pushes expected
// products and accept cycles, the monitor pops and compares on each output.
module tb_booth_pp_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] pp0, pp1, pp2, pp3;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;
`ifdef BOOTH_ACC_OVF_EN
  logic        ovf;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] exp_q [$];
  logic        ovf_q [$];
  int          lat_q [$];
  logic        ov_prev = 1'b0;

  booth_pp_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp0       (pp0),
    .pp1       (pp1),
    .pp2       (pp2),
    .pp3       (pp3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
`ifdef BOOTH_ACC_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Offer one set; on acceptance record expected result and accept cycle.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [15:0] d,
                      input logic [15:0] e, input logic eo, output int acc_at);
    int n;
    @(posedge clk); #1;
    pp0 = a; pp1 = b; pp2 = c; pp3 = d;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    acc_at = cyc + 1;
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    else begin
      exp_q.push_back(e);
      ovf_q.push_back(eo);
      lat_q.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: latency on each out_valid rise, value on each handshake.
  always @(negedge clk) begin
    if (!rst_n) ov_prev = 1'b0;
    else begin
      if (out_valid && !ov_prev) begin
        if (lat_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
        else chk("latency", 32'(cyc - lat_q.pop_front()), 32'd4);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_product", 32'(product), 32'hDEAD);
        else begin
          chk("product", 32'(product), 32'(exp_q.pop_front()));
`ifdef BOOTH_ACC_OVF_EN
          chk("ovf", 32'(ovf), 32'(ovf_q.pop_front()));
`else
          void'(ovf_q.pop_front());
`endif
        end
      end
      ov_prev = out_valid;
    end
  end

  initial begin
    int t1, t2, n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pp0 = '0; pp1 = '0; pp2 = '0; pp3 = '0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Basic: 3*5
    out_ready = 1'b1;
    send(16'h0003, 16'h000C, 16'h0000, 16'h0000, 16'h000F, 1'b0, t1);
    drain();
    @(negedge clk);
    chk("one_cycle_valid", 32'(out_valid), 32'd0);

    // Reset mid-ACC aborts the set (product 000F must clear)
    @(posedge clk); #1;
    pp0 = 16'h1111; pp1 = 16'h2222; pp2 = 16'h0; pp3 = 16'h0; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_ready", 32'(in_ready), 32'd1);
    repeat (8) @(negedge clk);

    // Negative: -7*3
    send(16'h0007, 16'hFFE4, 16'h0000, 16'h0000, 16'hFFEB, 1'b0, t1);
    drain();

    // Backpressure
    @(posedge clk); #1 out_ready = 1'b0;
    send(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000A, 1'b0, t1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin n++; @(negedge clk); end
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_product", 32'(product), 32'h000A);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      pp0 = 16'hFFFF; pp1 = 16'h1234; pp2 = 16'h0; pp3 = 16'h0; in_valid = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_hold_product", 32'(product), 32'h000A);
    drain();

    // Back-to-back
    send(16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h000F, 1'b0, t1);
    send(16'hFF80, 16'h0000, 16'h0000, 16'h0000, 16'hFF80, 1'b0, t2);
    chk("b2b_spacing", 32'(t2 - t1), 32'd6);
    drain();

    // Overflow boundary; product wraps in both builds
    send(16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h8000, 1'b1, t1);
    drain();
    send(16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0004, 1'b0, t1);
    drain();

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
